// File: rtl/frame_tx_encoder_pkg.sv
// ---------------------------------------------------------------------------
// frame_tx_encoder_pkg
//   Shared definitions for the response-frame encoder. The SOF/EOF framing
//   bytes are the same values the command frame receiver looks for.
//
//   Contents:
//     data_t          8-bit byte type
//     frame_state_e   encoder FSM state encoding
//     SOF_BYTE/EOF_BYTE framing constants
//     len_byte()      LEN field value for a given payload count
//     is_byte_state() true in states that put a byte on the UART
// ---------------------------------------------------------------------------
package frame_tx_encoder_pkg;

  localparam int MAX_PAYLOAD_DEF = 16;
  localparam int LEN_W_DEF       = 5;

  typedef logic [7:0] data_t;

  localparam data_t SOF_BYTE = 8'hFE;
  localparam data_t EOF_BYTE = 8'hEF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_CMD,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_PAYLOAD,
    ST_EOF,
    ST_DONE
  } frame_state_e;

  // LEN counts everything after itself: CMD, the payload and EOF.
  function automatic data_t len_byte(input data_t payload_count);
    return payload_count + 8'd2;
  endfunction

  function automatic logic is_byte_state(input frame_state_e s);
    return (s == ST_SOF) || (s == ST_LEN) || (s == ST_CMD) ||
           (s == ST_PAYLOAD) || (s == ST_EOF);
  endfunction

endpackage

// File: rtl/frame_tx_encoder_if.sv
// ---------------------------------------------------------------------------
// frame_tx_encoder_if
//   Bundles the three handshakes around the encoder:
//     request side : req_valid, req_ready, req_cmd, req_len
//     result FIFO  : fifo_rd_en, fifo_data, fifo_empty
//     UART TX core : tx_ready, tx_send, tx_data
//     status       : busy, done, err
//   master : the surroundings (processor, FIFO, UART, or a bench)
//   slave  : the encoder itself
// ---------------------------------------------------------------------------
interface frame_tx_encoder_if #(
  parameter int LEN_W = 5
);
  import frame_tx_encoder_pkg::*;

  logic             req_valid;
  logic             req_ready;
  data_t            req_cmd;
  logic [LEN_W-1:0] req_len;

  logic             fifo_rd_en;
  data_t            fifo_data;
  logic             fifo_empty;

  logic             tx_ready;
  logic             tx_send;
  data_t            tx_data;

  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_cmd, req_len,
    output fifo_data, fifo_empty,
    output tx_ready,
    input  req_ready, fifo_rd_en, tx_send, tx_data, busy, done, err
  );

  modport slave (
    input  req_valid, req_cmd, req_len,
    input  fifo_data, fifo_empty,
    input  tx_ready,
    output req_ready, fifo_rd_en, tx_send, tx_data, busy, done, err
  );

endinterface

// File: rtl/frame_tx_encoder_tx_byte_issuer.sv
// ---------------------------------------------------------------------------
// frame_tx_encoder_tx_byte_issuer
//   Hands one byte at a time to the UART TX core.
//
//   Sequence per byte:
//     READY : issue_i && tx_ready_i -> latch byte, raise tx_send next cycle
//     SEND  : tx_send_o high for exactly one cycle
//     GUARD : tx_ready_i ignored while the UART drops it; byte_accepted_o
//             is high here so the FSM advances at the end of this cycle
//
//   Ports:
//     clk, rst          system clock, async active-low reset
//     issue_i           FSM is in a byte-sending state
//     byte_i            byte to send (sampled when the send is launched)
//     tx_ready_i        UART idle
//     tx_send_o         one-cycle send strobe
//     tx_data_o         byte on the UART bus, held until the next send
//     byte_accepted_o   one-cycle pulse, byte handed over
// ---------------------------------------------------------------------------
module frame_tx_encoder_tx_byte_issuer
  import frame_tx_encoder_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  issue_i,
  input  data_t byte_i,
  input  logic  tx_ready_i,
  output logic  tx_send_o,
  output data_t tx_data_o,
  output logic  byte_accepted_o
);

  logic  send_q, send_d;
  logic  guard_q, guard_d;
  data_t data_q, data_d;

  always_comb begin
    send_d  = 1'b0;
    guard_d = send_q;
    data_d  = data_q;
    // Neither the strobe cycle nor the guard cycle may launch a new byte,
    // which keeps at least two idle cycles between tx_send pulses.
    if (issue_i && tx_ready_i && !send_q && !guard_q) begin
      send_d = 1'b1;
      data_d = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      send_q  <= 1'b0;
      guard_q <= 1'b0;
      data_q  <= '0;
    end else begin
      send_q  <= send_d;
      guard_q <= guard_d;
      data_q  <= data_d;
    end
  end

  assign tx_send_o       = send_q;
  assign tx_data_o       = data_q;
  assign byte_accepted_o = guard_q;

endmodule

// File: rtl/frame_tx_encoder.sv
// ---------------------------------------------------------------------------
// frame_tx_encoder
//   Builds a response frame  SOF, LEN, CMD, payload..., EOF  and feeds it
//   byte by byte to the UART TX core. CMD and the payload count come from
//   the processor; payload bytes are popped one at a time from the result
//   FIFO.
//
//   Parameters:
//     MAX_PAYLOAD  largest accepted payload count
//     LEN_W        width of req_len (must hold MAX_PAYLOAD)
//
//   Ports:
//     clk   system clock
//     rst   asynchronous active-low reset
//     bus   frame_tx_encoder_if.slave (request, FIFO, UART, status)
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | req_ready=1, waiting for a request
//   SOF       | sending 8'hFE
//   LEN       | sending payload count + 2
//   CMD       | sending the latched command byte
//   FETCH     | waiting for a non-empty FIFO, then popping one byte
//   WAIT_DATA | waiting for the popped byte to appear on fifo_data
//   PAYLOAD   | sending the popped byte, counting down
//   EOF       | sending 8'hEF
//   DONE      | done pulse; back to IDLE next cycle
// ---------------------------------------------------------------------------
module frame_tx_encoder
  import frame_tx_encoder_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input logic               clk,
  input logic               rst,
  frame_tx_encoder_if.slave bus
);

  frame_state_e     state_q;
  data_t            cmd_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem_q;
  data_t            pay_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             rd_en_q;

  data_t            tx_byte;
  logic             issue;
  logic             byte_accepted;
  logic             tx_send;
  data_t            tx_data;

  assign issue = is_byte_state(state_q);

  always_comb begin
    tx_byte = SOF_BYTE;
    unique case (state_q)
      ST_LEN:     tx_byte = len_byte(data_t'(len_q));
      ST_CMD:     tx_byte = cmd_q;
      ST_PAYLOAD: tx_byte = pay_q;
      ST_EOF:     tx_byte = EOF_BYTE;
      default:    tx_byte = SOF_BYTE;
    endcase
  end

  frame_tx_encoder_tx_byte_issuer u_issuer (
    .clk             (clk),
    .rst             (rst),
    .issue_i         (issue),
    .byte_i          (tx_byte),
    .tx_ready_i      (bus.tx_ready),
    .tx_send_o       (tx_send),
    .tx_data_o       (tx_data),
    .byte_accepted_o (byte_accepted)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      pay_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_len > LEN_W'(MAX_PAYLOAD)) begin
              err_q <= 1'b1;
            end else begin
              cmd_q       <= bus.req_cmd;
              len_q       <= bus.req_len;
              rem_q       <= bus.req_len;
              busy_q      <= 1'b1;
              req_ready_q <= 1'b0;
              state_q     <= ST_SOF;
            end
          end
        end

        ST_SOF: if (byte_accepted) state_q <= ST_LEN;

        ST_LEN: if (byte_accepted) state_q <= ST_CMD;

        ST_CMD: begin
          if (byte_accepted) begin
            state_q <= (len_q == '0) ? ST_EOF : ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (!bus.fifo_empty) begin
            rd_en_q <= 1'b1;
            state_q <= ST_WAIT_DATA;
          end
        end

        // The pop strobe is registered, so it is still high during the
        // first WAIT_DATA cycle; the FIFO presents the byte one cycle
        // after that, once the strobe has dropped.
        ST_WAIT_DATA: begin
          if (!rd_en_q) begin
            pay_q   <= bus.fifo_data;
            state_q <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (byte_accepted) begin
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= (rem_q == LEN_W'(1)) ? ST_EOF : ST_FETCH;
          end
        end

        ST_EOF: begin
          if (byte_accepted) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.fifo_rd_en = rd_en_q;
  assign bus.tx_send    = tx_send;
  assign bus.tx_data    = tx_data;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
